systolic_feeder: RTL and testbench

Front-end transmitter for the N×N systolic MAC array. It holds one A matrix and one B matrix of 8-bit minifloat elements: 1 sign bit, 3-bit exponent with bias 3, 4-bit fraction, and 0x00 meaning zero. On start it streams A rows into the west edge and B columns into the north edge with diagonal skew, then zero-pads and signals completion. It drives the ain/bin inputs of the edge MAC cells, which forward values through apass/bpass.

---
 rtl/systolic_feeder.sv | 135 +++++++++++++
 tb/tb_systolic_feeder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Systolic array front-end: holds one A and one B minifloat matrix and streams
// A rows west / B columns north with diagonal skew, then drains and pulses done.
module systolic_feeder #(
    parameter int N = 3,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [$clog2(N)-1:0] wr_row,
    input  logic [$clog2(N)-1:0] wr_col,
    input  logic [W-1:0]         wr_data,
    input  logic                 start,
    output logic [N*W-1:0]       a_out,
    output logic [N*W-1:0]       b_out,
    output logic                 feed_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int IW        = $clog2(N);
    localparam int TW        = $clog2(4 * N);
    localparam int FEED_LAST = 3 * N - 3;
    localparam int DRAIN_LAST = N - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [TW-1:0]           t_q;
    logic [W-1:0]            a_mem_q [N][N];
    logic [W-1:0]            b_mem_q [N][N];
    logic [N-1:0][W-1:0]     a_d, b_d, a_q, b_q;
    logic                    fv_q, busy_q, done_q;
    logic                    wr_ok;

    assign wr_ok = wr_en && (state_q == S_IDLE)
                   && (int'(wr_row) < N) && (int'(wr_col) < N);

    // Lane i carries the element whose wavefront reaches edge cell i at step t.
    always_comb begin
        int unsigned tv;
        int unsigned k;
        a_d = '0;
        b_d = '0;
        tv  = 32'(t_q);
        k   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (tv >= i && (tv - i) < N) begin
                k = tv - i;
                a_d[IW'(i)] = a_mem_q[IW'(i)][IW'(k)];
                b_d[IW'(i)] = b_mem_q[IW'(k)][IW'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    a_mem_q[IW'(r)][IW'(c)] <= '0;
                    b_mem_q[IW'(r)][IW'(c)] <= '0;
                end
            end
        end else begin
            if (wr_ok) begin
                if (wr_sel)
                    b_mem_q[wr_row][wr_col] <= wr_data;
                else
                    a_mem_q[wr_row][wr_col] <= wr_data;
            end

            a_q    <= '0;
            b_q    <= '0;
            fv_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;

            unique case (state_q)
                // Outputs lag state by one edge, so done_q marks the visible DONE cycle.
                S_IDLE: begin
                    if (start && !done_q) begin
                        state_q <= S_FEED;
                        t_q     <= '0;
                    end
                end
                S_FEED: begin
                    a_q    <= a_d;
                    b_q    <= b_d;
                    fv_q   <= 1'b1;
                    busy_q <= 1'b1;
                    if (t_q == TW'(FEED_LAST)) begin
                        state_q <= S_DRAIN;
                        t_q     <= '0;
                    end else begin
                        t_q <= t_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    busy_q <= 1'b1;
                    if (t_q == TW'(DRAIN_LAST)) begin
                        state_q <= S_DONE;
                        t_q     <= '0;
                    end else begin
                        t_q <= t_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign a_out      = a_q;
    assign b_out      = b_q;
    assign feed_valid = fv_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=3): skew tables, pass timing, lockout,
// mid-pass reset and out-of-range writes, all against hand-computed vectors.
module tb_systolic_feeder;

    localparam int N  = 3;
    localparam int NF = 3 * N - 2;

    logic          clk = 1'b0;
    logic          rst, wr_en, wr_sel, start;
    logic [1:0]    wr_row, wr_col;
    logic [7:0]    wr_data;
    logic [23:0]   a_out, b_out;
    logic          feed_valid, busy, done;

    int checks = 0;
    int errors = 0;

    logic [23:0] ea2 [NF];
    logic [23:0] eb2 [NF];
    logic [23:0] eb3 [NF];
    logic [23:0] ez  [NF];

    always #5 clk = ~clk;

    systolic_feeder #(.N(N), .W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .start      (start),
        .a_out      (a_out),
        .b_out      (b_out),
        .feed_valid (feed_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_el(input logic sel, input logic [1:0] r, input logic [1:0] c,
                            input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_row = r; wr_col = c; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_a"}, 32'(a_out), 32'h0);
        chk({tag, "_b"}, 32'(b_out), 32'h0);
        chk({tag, "_fv"}, 32'(feed_valid), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
    endtask

    // Caller may preset wr_* to exercise a write coincident with start.
    task automatic run_pass(input string tag, input logic [23:0] ea [NF],
                            input logic [23:0] eb [NF], input int inj);
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        for (int j = 1; j <= 4 * N - 1; j++) begin
            tick();
            if (j <= NF) begin
                chk($sformatf("%s_a_t%0d", tag, j - 1), 32'(a_out), 32'(ea[j-1]));
                chk($sformatf("%s_b_t%0d", tag, j - 1), 32'(b_out), 32'(eb[j-1]));
                chk($sformatf("%s_fv_t%0d", tag, j - 1), 32'(feed_valid), 32'h1);
                chk($sformatf("%s_busy_t%0d", tag, j - 1), 32'(busy), 32'h1);
                chk($sformatf("%s_done_t%0d", tag, j - 1), 32'(done), 32'h0);
            end else if (j <= 4 * N - 2) begin
                chk($sformatf("%s_drain_a%0d", tag, j), 32'(a_out), 32'h0);
                chk($sformatf("%s_drain_b%0d", tag, j), 32'(b_out), 32'h0);
                chk($sformatf("%s_drain_fv%0d", tag, j), 32'(feed_valid), 32'h0);
                chk($sformatf("%s_drain_busy%0d", tag, j), 32'(busy), 32'h1);
                chk($sformatf("%s_drain_done%0d", tag, j), 32'(done), 32'h0);
            end else begin
                chk({tag, "_done"}, 32'(done), 32'h1);
                chk({tag, "_done_busy"}, 32'(busy), 32'h0);
                chk({tag, "_done_fv"}, 32'(feed_valid), 32'h0);
            end
            wr_en = 1'b0;
            start = (j == inj) || (j >= 4 * N - 2);
            if (j == inj) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'h7F;
            end
        end
        tick();
        start = 1'b0;
        chk({tag, "_post_done"}, 32'(done), 32'h0);
        chk({tag, "_post_busy"}, 32'(busy), 32'h0);
        tick();
        chk({tag, "_post2_busy"}, 32'(busy), 32'h0);
        chk({tag, "_post2_fv"}, 32'(feed_valid), 32'h0);
    endtask

    task automatic load_a_tab2();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                write_el(1'b0, 2'(r), 2'(c), 8'(8'h30 + r * 3 + c));
    endtask

    initial begin
        bit seen_done;
        bit seen_busy;

        ea2 = '{24'h000030, 24'h003331, 24'h363432, 24'h373500, 24'h380000, 24'h0, 24'h0};
        eb2 = '{24'h000040, 24'h004040, 24'h404040, 24'h404000, 24'h400000, 24'h0, 24'h0};
        eb3 = '{24'h000040, 24'h004143, 24'h424446, 24'h454700, 24'h480000, 24'h0, 24'h0};
        ez  = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};

        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
        wr_data = '0; start = 1'b0;

        // 1: reset and an empty pass
        tick();
        tick();
        check_idle("rst_hold");
        rst = 1'b0;
        tick();
        check_idle("rst_rel");
        run_pass("empty", ez, ez, 0);

        // 2: A skew with B all 0x40
        load_a_tab2();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                write_el(1'b1, 2'(r), 2'(c), 8'h40);
        run_pass("skewA", ea2, eb2, 0);

        // 3: B skew with A zero
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                write_el(1'b0, 2'(r), 2'(c), 8'h00);
                write_el(1'b1, 2'(r), 2'(c), 8'(8'h40 + r * 3 + c));
            end
        run_pass("skewB", ez, eb3, 0);

        // 4: write + start during FEED are ignored
        load_a_tab2();
        run_pass("lock1", ea2, eb3, 3);
        run_pass("lock2", ea2, eb3, 0);

        // 5: reset mid-pass
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_a_t2", 32'(a_out), 32'h363432);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("mid_rst");
        seen_done = 1'b0;
        seen_busy = 1'b0;
        for (int j = 0; j < 4 * N + 2; j++) begin
            tick();
            seen_done |= done;
            seen_busy |= busy;
        end
        chk("mid_no_done", 32'(seen_done), 32'h0);
        chk("mid_no_busy", 32'(seen_busy), 32'h0);
        run_pass("cleared", ez, ez, 0);

        // 6: out-of-range writes ignored; last B write coincides with start
        load_a_tab2();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (!(r == 2 && c == 2)) write_el(1'b1, 2'(r), 2'(c), 8'h40);
        write_el(1'b0, 2'd3, 2'd0, 8'h55);
        write_el(1'b1, 2'd3, 2'd1, 8'h55);
        write_el(1'b0, 2'd1, 2'd3, 8'h55);
        wr_en = 1'b1; wr_sel = 1'b1; wr_row = 2'd2; wr_col = 2'd2; wr_data = 8'h40;
        run_pass("oor", ea2, eb2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
